// File: rtl/seq_multiplier_if.sv
// Request/result bundle between the ALU front end and seq_multiplier.
// master drives operands and the level request; slave returns the product.
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                   mult_begin;
    logic                   mult_signed;
    logic [WIDTH-1:0]       mult_op1;
    logic [WIDTH-1:0]       mult_op2;
    logic [2*WIDTH-1:0]     product;
    logic                   mult_end;
    logic                   busy;

    modport master (
        output mult_begin,
        output mult_signed,
        output mult_op1,
        output mult_op2,
        input  product,
        input  mult_end,
        input  busy
    );

    modport slave (
        input  mult_begin,
        input  mult_signed,
        input  mult_op1,
        input  mult_op2,
        output product,
        output mult_end,
        output busy
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add WIDTH x WIDTH multiplier, one multiplier bit per clock.
// SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are 0.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    seq_multiplier_if.slave  mif
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      product_q, product_d;
    logic               end_q, end_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   mag1, mag2;
    logic               op1_neg, op2_neg;
    logic [PW-1:0]      acc_add;
    logic [PW-1:0]      fin_val;

    // Operand magnitudes: negate only signed negatives. The most negative
    // value maps onto itself, which is its correct unsigned magnitude.
    always_comb begin
        op1_neg = mif.mult_signed & mif.mult_op1[WIDTH-1];
        op2_neg = mif.mult_signed & mif.mult_op2[WIDTH-1];
        mag1    = op1_neg ? (~mif.mult_op1 + WIDTH'(1)) : mif.mult_op1;
        mag2    = op2_neg ? (~mif.mult_op2 + WIDTH'(1)) : mif.mult_op2;
    end

    // Accumulator step for the current multiplier bit.
    always_comb begin
        acc_add = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        busy_d    = busy_q;
        fin_val   = acc_add;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (mif.mult_begin) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag1};
                    mplier_d = mag2;
                    neg_d    = op1_neg ^ op2_neg;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end
            end

            S_CALC: begin
                if (!mif.mult_begin) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
`ifdef SEQ_MULT_EARLY_EXIT_EN
                else if (mplier_q == '0) begin
                    fin_val   = acc_q;
                    product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
                    busy_d    = 1'b0;
                    state_d   = S_DONE;
                end
`endif
                else begin
                    acc_d    = acc_add;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        product_d = neg_q ? (~fin_val + PW'(1)) : fin_val;
                        busy_d    = 1'b0;
                        state_d   = S_DONE;
                    end
                end
            end

            S_DONE: begin
                busy_d = 1'b0;
                if (!mif.mult_begin) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // mult_end trails entry into DONE by one edge and falls on the
    // first edge that sees the request dropped.
    always_comb begin
        end_d = (state_q == S_DONE) & mif.mult_begin;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            end_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            end_q     <= end_d;
            busy_q    <= busy_d;
        end
    end

    assign mif.product  = product_q;
    assign mif.mult_end = end_q;
    assign mif.busy     = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed corner cases plus random
// operands, checked against plain 64-bit arithmetic.
module tb_seq_multiplier;
    localparam int W = 32;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    localparam logic [31:0] HB = 32'h8000_0000;
`else
    localparam logic [31:0] HB = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(W)) mif ();

    seq_multiplier #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] prod;
        int          start;
        int          lat;
    } exp_t;

    exp_t sb[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b, logic s);
        longint sa, sbv;
        logic [63:0] ua, ub;
        if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            return 64'(sa * sbv);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    function automatic int exp_lat(logic [31:0] b, logic s);
        logic [31:0] mag;
        int k, l;
        mag = (s && b[31]) ? (~b + 32'd1) : b;
        k = 0;
        for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        l = (k + 1 > W) ? W : k + 1;
`else
        l = W;
`endif
        return l + 1;
    endfunction

    logic prev_end = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mif.mult_end && !prev_end) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_end: got mult_end=1 at cycle %0d, required no result", cyc);
            end else begin
                e = sb.pop_front();
                chk("product", mif.product, e.prod);
                chk("latency", 64'(cyc - e.start), 64'(e.lat));
            end
        end
        prev_end <= mif.mult_end;
    end

    task automatic start(logic [31:0] a, logic [31:0] b, logic s, bit push);
        exp_t e;
        @(negedge clk);
        mif.mult_op1    = a;
        mif.mult_op2    = b;
        mif.mult_signed = s;
        mif.mult_begin  = 1'b1;
        if (push) begin
            e.prod  = ref_prod(a, b, s);
            e.start = cyc + 1;
            e.lat   = exp_lat(b, s);
            sb.push_back(e);
        end
    endtask

    task automatic run(logic [31:0] a, logic [31:0] b, logic s, int hold, bit scramble);
        int busy_n;
        int t;
        logic [63:0] p;
        busy_n = 0;
        t = 0;
        start(a, b, s, 1'b1);
        do begin
            @(negedge clk);
            t++;
            if (scramble && t == 2) begin
                mif.mult_op1    = $urandom;
                mif.mult_op2    = $urandom;
                mif.mult_signed = ~s;
            end
            if (mif.busy) busy_n++;
        end while (!mif.mult_end && t < 200);
        if (!mif.mult_end) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got no mult_end in %0d cycles, required %0d", t, exp_lat(b, s));
        end else begin
            chk("busy_cycles", 64'(busy_n), 64'(exp_lat(b, s) - 1));
        end
        p = mif.product;
        repeat (hold) @(negedge clk);
        chk("hold_end", 64'(mif.mult_end), 64'd1);
        chk("hold_product", mif.product, p);
        mif.mult_begin = 1'b0;
        @(negedge clk);
        chk("drop_end", 64'(mif.mult_end), 64'd0);
        chk("drop_busy", 64'(mif.busy), 64'd0);
        chk("drop_product", mif.product, p);
    endtask

    initial begin
        reset           = 1'b1;
        mif.mult_begin  = 1'b0;
        mif.mult_signed = 1'b0;
        mif.mult_op1    = '0;
        mif.mult_op2    = '0;
        repeat (3) @(negedge clk);
        chk("rst_product", mif.product, 64'd0);
        chk("rst_end", 64'(mif.mult_end), 64'd0);
        chk("rst_busy", 64'(mif.busy), 64'd0);
        reset = 1'b0;

        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, 1'b0);
        run(32'hFFFF_FFFD, 32'd7, 1'b1, 2, 1'b0);
        run(32'h8000_0000, 32'h8000_0000, 1'b1, 1, 1'b0);
        run(32'd0, 32'h1234_5678, 1'b1, 50, 1'b0);
        run(32'd100, 32'd3, 1'b0, 1, 1'b0);
        run(32'd100, 32'd0, 1'b0, 1, 1'b0);
        run(32'd100, 32'h8000_0000, 1'b0, 1, 1'b0);
        run(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0, 1'b0);

        // Abort mid-calculation keeps the earlier product.
        run(32'd3, 32'd4, 1'b0, 0, 1'b0);
        start(32'd5, 32'd6 | HB, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        mif.mult_begin = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(mif.busy), 64'd0);
        chk("abort_end", 64'(mif.mult_end), 64'd0);
        repeat (40) @(negedge clk);
        chk("abort_product", mif.product, 64'd12);

        // Reset during calculation, then a normal run.
        start(32'd7, 32'd9 | HB, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        reset          = 1'b1;
        mif.mult_begin = 1'b0;
        @(negedge clk);
        chk("midrst_product", mif.product, 64'd0);
        chk("midrst_end", 64'(mif.mult_end), 64'd0);
        chk("midrst_busy", 64'(mif.busy), 64'd0);
        reset = 1'b0;
        run(32'd7, 32'd9, 1'b0, 1, 1'b0);

        // Operand changes after the start edge must not matter.
        run(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1, 1'b1);
        run(32'h0001_0003, 32'h0000_0105, 1'b0, 1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = ~a;
            if ($urandom_range(0, 3) == 0) b = ~b;
            run(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative shift-add 32x32 multiplier; upstream producer of the 64-bit product and done flag consumed by the ALU display top. That top latches the product into its HIGH/LOW result registers.
- Started by a level request (held high while the multiply op is selected).
- One multiplier bit retired per clock; optional signed mode; result held until the request drops.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mult_begin  input  1  level request; high = compute/hold, low = abort/idle.
- mult_signed  input  1  1 = operands are two's complement, 0 = unsigned; sampled at start only.
- mult_op1  input  WIDTH  multiplicand; sampled at start only.
- mult_op2  input  WIDTH  multiplier; sampled at start only.
- product  output  2*WIDTH  result register.
- mult_end  output  1  high while a valid result is held.
- busy  output  1  high while in CALC.

Behaviour:
- Reset (reset=1 at an edge): state=IDLE; product=0; mult_end=0; busy=0; counter=0; internal accumulator and shift registers cleared. Reset overrides all other inputs, including mid-CALC.
- States: IDLE, CALC, DONE.
- IDLE, mult_begin=1 (the start edge):
  - Latch |op1| into multiplicand register, WIDTH-bit zero-extended to 2*WIDTH. |x| is taken only when mult_signed=1 and the MSB is 1; otherwise the raw value.
  - Latch |op2| into multiplier shift register.
  - neg = mult_signed & (op1[MSB] ^ op2[MSB]).
  - Accumulator=0; counter=WIDTH; go CALC; busy=1 from the next cycle.
- IDLE, mult_begin=0: stay; outputs unchanged (product keeps its last value).
- CALC, each edge with mult_begin=1:
  - If multiplier[0], accumulator += multiplicand.
  - Multiplicand <<= 1; multiplier >>= 1; counter -= 1.
  - On the edge where counter goes 1->0: product = neg ? -(acc_next) : acc_next (2*WIDTH-bit two's complement); mult_end=1; busy=0; go DONE.
- Latency: mult_end is first visible WIDTH+1 cycles after the start edge; 33 for WIDTH=32.
- CALC, mult_begin=0 (abort): next edge -> IDLE; busy=0; mult_end stays 0; product not updated.
- DONE: hold product and mult_end=1 while mult_begin=1. On the first edge with mult_begin=0, go IDLE and set mult_end=0; product holds.
- Restart requires mult_begin low for >=1 edge; no auto-restart from DONE.
- Operand or mult_signed changes after the start edge are ignored.
- Arithmetic: the accumulator is 2*WIDTH bits and never overflows.
- Most-negative operand: signed -2^(WIDTH-1) has magnitude 2^(WIDTH-1), representable unsigned. (-2^31)*(-2^31)=2^62 is exact.
- Zero operand gives product 0, regardless of neg.
- Unsigned mode: the full unsigned 64-bit product.

Optional Feature:
- Macro SEQ_MULT_EARLY_EXIT_EN.
- Defined: at any CALC edge where the multiplier shift register is already 0, go DONE immediately; product is the sign-corrected accumulator, with no add or shift on that edge.
  - Let k = index of the highest set bit of |op2| + 1 (k=0 when |op2|=0).
  - Number of CALC edges L = min(k+1, WIDTH); mult_end is visible L+1 cycles after the start edge.
- Undefined: fixed WIDTH CALC edges; the zero-detect logic is absent.
- Results are identical either way.

Test Plan:
- Reset mid-CALC (start 7*9, assert reset at cycle 10) -> next cycle: IDLE, product=0, mult_end=0, busy=0; a new start then works normally.
- Unsigned: op1=0xFFFFFFFF, op2=0xFFFFFFFF, signed=0 -> product=0xFFFFFFFE_00000001. mult_end rises exactly 33 cycles after the start edge; busy is high for 32 cycles.
- Signed: op1=0xFFFFFFFD (-3), op2=7, signed=1 -> product=0xFFFFFFFF_FFFFFFEB (-21). Also op1=op2=0x80000000, signed=1 -> 0x40000000_00000000.
- Zero and hold: op1=0, op2=0x12345678, signed=1 -> product=0, mult_end=1. Hold mult_begin 50 cycles -> values stable. Drop mult_begin -> mult_end=0 next cycle, product still 0.
- Abort: start 5*6, drop mult_begin after 10 CALC cycles -> IDLE, mult_end never asserts, product keeps its previous result. Changing op1/op2 during CALC of a separate run does not affect that run's result.
- Early exit (macro on): op1=100, op2=3, unsigned -> product=300, mult_end at start+4 (L=3). Op2=0 -> product=0 at start+2. Op2=0x80000000 -> start+33. Macro off: all cases at start+33.
